symbol_sink: RTL and testbench
==============================

// Module: symbol_sink
// PURPOSE
//  Receiving end of the symbol stream produced by the symbol source (data/valid/ready + addr tag).
//  Captures accepted symbols into an on-chip buffer, checks addr-tag continuity to detect
//  dropped/repeated symbols, and exposes a synchronous readback port for the checker/UART dump.
//  Sits between the source and the debug/readout logic in the QAM test path.
// PARAMETERS
//  DATA_WIDTH  4   symbol width (bits per QAM symbol)
//  ADDR_WIDTH  32  width of source addr tag in_addr
//  BUF_AW      8   capture buffer address width; DEPTH = 2**BUF_AW
//  CNT_WIDTH   16  width of err_count (saturating)
// PORTS
//  clk         in   1           clock
//  rst         in   1           reset, synchronous, active-high
//  start       in   1           1-cycle pulse: arm capture (restarts if already running/done)
//  continuous  in   1           sampled on start: 1 = wrap buffer forever, 0 = one-shot
//  hold        in   1           backpressure request: forces in_ready=0 while high
//  in_data     in   DATA_WIDTH  symbol from source
//  in_valid    in   1           source valid
//  in_addr     in   ADDR_WIDTH  source addr tag for in_data
//  in_ready    out  1           sink ready
//  rd_addr     in   BUF_AW      readback address
//  rd_data     out  DATA_WIDTH  buffer[rd_addr], 1-cycle latency
//  wr_count    out  BUF_AW+1    symbols stored since start (saturates at DEPTH)
//  err_count   out  CNT_WIDTH   addr-tag discontinuities since start (saturating)
//  busy        out  1           high in CAPTURE
//  done        out  1           high in DONE (one-shot buffer full)
//  wrapped     out  1           continuous mode: write pointer has wrapped at least once
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=0, busy=0, done=0, wrapped=0, wr_count=0, err_count=0,
//   wptr=0, sync=0. rd_data reset to 0. Buffer contents NOT cleared. Reset mid-capture aborts.
//  FSM: IDLE --start--> CAPTURE; CAPTURE --last one-shot write--> DONE; DONE --start--> CAPTURE;
//   CAPTURE --start--> CAPTURE (restart). start in any state clears wptr, wr_count, err_count,
//   wrapped, sync and latches mode from continuous.
//  in_ready = (state==CAPTURE) && !hold; combinational from registered state and hold only,
//   never from in_valid. Beat accepted iff in_valid && in_ready on a rising edge.
//  Accept: buffer[wptr] <= in_data; wptr <= wptr+1 (mod DEPTH); wr_count <= min(wr_count+1, DEPTH).
//  One-shot: the accept at wptr==DEPTH-1 moves to DONE next cycle; in_ready=0 from that cycle.
//  Continuous: wptr wraps DEPTH-1 -> 0, wrapped <= 1; never enters DONE.
//  Tag check: first accept after start sets exp <= in_addr+1, sync <= 1, no error.
//   Later accepts: if in_addr != exp -> err_count+1 (saturate at all-ones); always exp <= in_addr+1
//   (resync). exp arithmetic modulo 2**ADDR_WIDTH (all-ones -> 0 is NOT an error).
//  start and accept in same cycle: start wins, beat discarded (not written, not checked).
//  Readback: rd_data registered, read-first: same-cycle write to rd_addr returns old contents.
//   Readback legal in any state.
// STRUCTURE
//  qam_pkg: symbol_t (logic [DATA_WIDTH-1:0]), sink_state_t enum {IDLE, CAPTURE, DONE}.
//  Sub-module sink_ram: simple dual-port RAM, 1 write port, 1 registered read port, depth
//   2**BUF_AW, read-first; top holds FSM, pointer, counters and tag checker.
// TESTING
//  1 One-shot, BUF_AW=3, source tags 0..7 valid every cycle -> 8 accepts, done=1 cycle after
//    8th, in_ready=0, wr_count=8, err_count=0, readback 0..7 returns sent symbols.
//  2 Tag gap: tags 0,1,2,4,5 -> err_count=1 after beat with tag 4; tag 5 not an error.
//  3 Continuous, BUF_AW=3, 12 beats -> wrapped=1, wr_count=8, buffer[0..3] = beats 8..11.
//  4 hold toggled every other cycle, in_valid held high -> no beat lost/duplicated,
//    tags continuous, err_count=0.
//  5 start pulse coincident with an accepted beat mid-capture -> beat dropped, wr_count=0,
//    err_count=0, next beat written at address 0 with no tag error.
//  6 rst asserted mid-capture -> all outputs at reset values next cycle; tag wrap
//    0xFFFFFFFF -> 0 after restart gives err_count=0.

Source files
------------

// File: rtl/qam_pkg.sv
// Shared types and defaults for the QAM symbol test path.
package qam_pkg;

   localparam int DEF_DATA_WIDTH = 4;
   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_BUF_AW     = 8;
   localparam int DEF_CNT_WIDTH  = 16;

   typedef logic [DEF_DATA_WIDTH-1:0] symbol_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } sink_state_t;

endpackage

// File: rtl/symbol_sink_if.sv
// Symbol stream between source and sink: data + addr tag with valid/ready.
//
// Handshake: a beat transfers on a rising clk edge where in_valid && in_ready.
// The source holds in_data/in_addr stable while in_valid is high and not yet
// accepted; in_ready never depends on in_valid.
interface symbol_sink_if #(
   parameter int DATA_WIDTH = 4,
   parameter int ADDR_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic [ADDR_WIDTH-1:0] in_addr;
   logic                  in_ready;

   modport master (output in_data, output in_valid, output in_addr, input in_ready);
   modport slave  (input in_data, input in_valid, input in_addr, output in_ready);
endinterface

// File: rtl/sink_ram.sv
// Capture buffer: one write port, one registered read port, read-first.
module sink_ram #(
   parameter int DW = 4,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   localparam int DEPTH = 2**AW;

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rd_data_d;
   logic [DW-1:0] rd_data_q;

   // Read the array before this edge's write lands, giving read-first behaviour.
   always_comb begin
      rd_data_d = mem[raddr];
   end

   // Array write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read output, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rdata = rd_data_q;
endmodule

// File: rtl/symbol_sink.sv
// Receiving end of the symbol stream: captures accepted symbols into a buffer,
// checks addr-tag continuity, and offers a registered readback port.
module symbol_sink
   import qam_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int BUF_AW     = DEF_BUF_AW,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  continuous,
   input  logic                  hold,
   symbol_sink_if.slave          in_if,
   input  logic [BUF_AW-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [BUF_AW:0]       wr_count,
   output logic [CNT_WIDTH-1:0]  err_count,
   output logic                  busy,
   output logic                  done,
   output logic                  wrapped,
   output sink_state_t           dbg_state
);
   localparam logic [BUF_AW:0]   WR_FULL  = {1'b1, {BUF_AW{1'b0}}};
   localparam logic [BUF_AW-1:0] PTR_LAST = {BUF_AW{1'b1}};

   sink_state_t           state_q, state_d;
   logic [BUF_AW-1:0]     wptr_q, wptr_d;
   logic [BUF_AW:0]       wr_count_q, wr_count_d;
   logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;
   logic                  wrapped_q, wrapped_d;
   logic                  sync_q, sync_d;
   logic                  mode_q, mode_d;
   logic [ADDR_WIDTH-1:0] exp_q, exp_d;

   logic                  ready;
   logic                  accept;

   // Ready comes only from registered state and hold; a start in the same
   // cycle overrides the beat so it is neither written nor checked.
   assign ready  = (state_q == CAPTURE) && !hold;
   assign accept = in_if.in_valid && ready && !start;

   // Next-state, pointer, counter and tag-check logic.
   always_comb begin
      state_d     = state_q;
      wptr_d      = wptr_q;
      wr_count_d  = wr_count_q;
      err_count_d = err_count_q;
      wrapped_d   = wrapped_q;
      sync_d      = sync_q;
      mode_d      = mode_q;
      exp_d       = exp_q;

      if (start) begin
         state_d     = CAPTURE;
         wptr_d      = '0;
         wr_count_d  = '0;
         err_count_d = '0;
         wrapped_d   = 1'b0;
         sync_d      = 1'b0;
         mode_d      = continuous;
      end else if (accept) begin
         wptr_d = wptr_q + 1'b1;
         if (wr_count_q != WR_FULL) begin
            wr_count_d = wr_count_q + 1'b1;
         end
         if (wptr_q == PTR_LAST) begin
            if (mode_q) begin
               wrapped_d = 1'b1;
            end else begin
               state_d = DONE;
            end
         end
         // The first beat after start only establishes the expected tag.
         if (sync_q && (in_if.in_addr != exp_q) && (err_count_q != {CNT_WIDTH{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
         end
         exp_d  = in_if.in_addr + 1'b1;
         sync_d = 1'b1;
      end
   end

   // State and bookkeeping registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wptr_q      <= '0;
         wr_count_q  <= '0;
         err_count_q <= '0;
         wrapped_q   <= 1'b0;
         sync_q      <= 1'b0;
         mode_q      <= 1'b0;
         exp_q       <= '0;
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         wr_count_q  <= wr_count_d;
         err_count_q <= err_count_d;
         wrapped_q   <= wrapped_d;
         sync_q      <= sync_d;
         mode_q      <= mode_d;
         exp_q       <= exp_d;
      end
   end

   sink_ram #(
      .DW (DATA_WIDTH),
      .AW (BUF_AW)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (accept),
      .waddr (wptr_q),
      .wdata (in_if.in_data),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   assign in_if.in_ready = ready;
   assign wr_count       = wr_count_q;
   assign err_count      = err_count_q;
   assign busy           = (state_q == CAPTURE);
   assign done           = (state_q == DONE);
   assign wrapped        = wrapped_q;
   assign dbg_state      = state_q;
endmodule

// File: tb/tb_symbol_sink.sv
// Bench for symbol_sink with an 8-entry buffer: directed beats, a behavioural
// model checked every cycle, and literal expectations for the key scenarios.
module tb_symbol_sink;
   import qam_pkg::*;

   localparam int DW    = 4;
   localparam int AW    = 32;
   localparam int BAW   = 3;
   localparam int CW    = 16;
   localparam int DEPTH = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic            continuous = 1'b0;
   logic            hold = 1'b0;
   logic [BAW-1:0]  rd_addr = '0;
   logic [DW-1:0]   rd_data;
   logic [BAW:0]    wr_count;
   logic [CW-1:0]   err_count;
   logic            busy, done, wrapped;
   sink_state_t     dbg_state;

   symbol_sink_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) sif ();

   int n_cmp  = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;
   bit toggle_en = 1'b0;

   always #5 clk = ~clk;

   symbol_sink #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .BUF_AW     (BAW),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .continuous (continuous),
      .hold       (hold),
      .in_if      (sif.slave),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .wr_count   (wr_count),
      .err_count  (err_count),
      .busy       (busy),
      .done       (done),
      .wrapped    (wrapped),
      .dbg_state  (dbg_state)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_known [DEPTH];
   bit            m_cap, m_done, m_mode, m_wrapped, m_have;
   int            m_wp, m_count, m_err;
   logic [AW-1:0] m_last, m_next;
   logic [DW-1:0] m_rd;
   bit            m_rd_known;

   initial begin
      for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
      m_cap = 0; m_done = 0; m_mode = 0; m_wrapped = 0; m_have = 0;
      m_wp = 0; m_count = 0; m_err = 0; m_last = '0; m_rd = '0; m_rd_known = 0;
   end

   always @(posedge clk) begin
      if (rst) begin
         m_cap = 0; m_done = 0; m_wrapped = 0; m_have = 0; m_mode = 0;
         m_wp = 0; m_count = 0; m_err = 0;
         m_rd = '0; m_rd_known = 1;
      end else begin
         m_rd_known = m_known[rd_addr];
         m_rd       = m_mem[rd_addr];
         if (start) begin
            m_cap = 1; m_done = 0; m_wrapped = 0; m_have = 0;
            m_wp = 0; m_count = 0; m_err = 0; m_mode = continuous;
         end else if (m_cap && !hold && sif.in_valid) begin
            m_mem[m_wp]   = sif.in_data;
            m_known[m_wp] = 1'b1;
            m_wp = (m_wp + 1) % DEPTH;
            if (m_count < DEPTH) m_count++;
            if (m_wp == 0) begin
               if (m_mode) m_wrapped = 1;
               else begin m_cap = 0; m_done = 1; end
            end
            m_next = m_last + 1;
            if (m_have && sif.in_addr != m_next && m_err < 65535) m_err++;
            m_last = sif.in_addr;
            m_have = 1;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_in_ready", sif.in_ready, m_cap && !hold);
         chk("cyc_busy", busy, m_cap);
         chk("cyc_done", done, m_done);
         chk("cyc_wrapped", wrapped, m_wrapped);
         chk("cyc_wr_count", wr_count, m_count);
         chk("cyc_err_count", err_count, m_err);
         if (m_rd_known) chk("cyc_rd_data", rd_data, m_rd);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_start(input logic cont);
      start = 1'b1; continuous = cont;
      @(posedge clk); #1;
      start = 1'b0; continuous = 1'b0;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic [AW-1:0] a);
      int   budget;
      logic ok;
      budget = 50;
      sif.in_valid = 1'b1; sif.in_data = d; sif.in_addr = a;
      do begin
         @(negedge clk); ok = sif.in_ready;
         @(posedge clk); #1;
         if (toggle_en) hold = ~hold;
         budget--;
      end while (!ok && budget > 0);
      if (!ok) begin
         n_cmp++; n_fail++;
         $display("FAIL send_timeout: beat tag %0h not accepted in budget", a);
      end
      sif.in_valid = 1'b0;
   endtask

   task automatic readback(input logic [BAW-1:0] a, input logic [DW-1:0] exp, input string name);
      rd_addr = a;
      @(posedge clk); #1;
      chk(name, rd_data, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [DW-1:0] t1 [8] = '{4'd3, 4'd8, 4'd13, 4'd2, 4'd7, 4'd12, 4'd1, 4'd6};
   logic [AW-1:0] t2 [5] = '{32'd0, 32'd1, 32'd2, 32'd4, 32'd5};
   int            t2e [5] = '{0, 0, 0, 1, 1};
   logic [AW-1:0] t6 [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};

   initial begin
      sif.in_valid = 1'b0; sif.in_data = '0; sif.in_addr = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      cmp_en = 1'b1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_in_ready", sif.in_ready, 1'b0);
      chk("rst_wr_count", wr_count, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_rd_data", rd_data, 0);

      // 1: one-shot fill
      do_start(1'b0);
      for (int i = 0; i < 8; i++) send(t1[i], 32'(i));
      chk("t1_done", done, 1'b1);
      chk("t1_in_ready", sif.in_ready, 1'b0);
      chk("t1_wr_count", wr_count, 8);
      chk("t1_err_count", err_count, 0);
      for (int i = 0; i < 8; i++) readback(BAW'(i), t1[i], "t1_readback");

      // 2: tag gap
      do_start(1'b0);
      for (int i = 0; i < 5; i++) begin
         send(4'(i + 1), t2[i]);
         chk("t2_err_count", err_count, t2e[i]);
      end

      // 3: continuous wrap
      do_start(1'b1);
      for (int i = 0; i < 12; i++) send(4'(i), 32'(100 + i));
      chk("t3_wrapped", wrapped, 1'b1);
      chk("t3_wr_count", wr_count, 8);
      chk("t3_busy", busy, 1'b1);
      chk("t3_done", done, 1'b0);
      for (int i = 0; i < 4; i++) readback(BAW'(i), 4'(8 + i), "t3_readback_new");
      for (int i = 4; i < 8; i++) readback(BAW'(i), 4'(i), "t3_readback_old");

      // 4: hold toggling every cycle with valid held
      do_start(1'b0);
      toggle_en = 1'b1;
      for (int i = 0; i < 8; i++) send(4'(15 - i), 32'(20 + i));
      toggle_en = 1'b0; hold = 1'b0;
      chk("t4_done", done, 1'b1);
      chk("t4_wr_count", wr_count, 8);
      chk("t4_err_count", err_count, 0);
      for (int i = 0; i < 8; i++) readback(BAW'(i), 4'(15 - i), "t4_readback");

      // 5: start coincident with an accepted beat
      do_start(1'b0);
      for (int i = 0; i < 3; i++) send(4'(i + 4), 32'(40 + i));
      start = 1'b1; sif.in_valid = 1'b1; sif.in_data = 4'd9; sif.in_addr = 32'd43;
      @(posedge clk); #1;
      start = 1'b0; sif.in_valid = 1'b0;
      chk("t5_wr_count", wr_count, 0);
      chk("t5_err_count", err_count, 0);
      chk("t5_busy", busy, 1'b1);
      send(4'd5, 32'd200);
      chk("t5_err_after", err_count, 0);
      chk("t5_wr_after", wr_count, 1);
      readback(BAW'(0), 4'd5, "t5_readback0");

      // 6: reset mid-capture, then tag wrap across all-ones
      do_start(1'b1);
      send(4'd1, 32'd300);
      send(4'd2, 32'd301);
      rst = 1'b1; sif.in_valid = 1'b1; sif.in_data = 4'd3; sif.in_addr = 32'd302;
      @(posedge clk); #1;
      sif.in_valid = 1'b0;
      chk("t6_rst_busy", busy, 1'b0);
      chk("t6_rst_done", done, 1'b0);
      chk("t6_rst_wrapped", wrapped, 1'b0);
      chk("t6_rst_wr_count", wr_count, 0);
      chk("t6_rst_err_count", err_count, 0);
      chk("t6_rst_in_ready", sif.in_ready, 1'b0);
      chk("t6_rst_rd_data", rd_data, 0);
      rst = 1'b0;
      do_start(1'b0);
      for (int i = 0; i < 4; i++) send(4'(10 + i), t6[i]);
      chk("t6_wrap_err", err_count, 0);
      chk("t6_wr_count", wr_count, 4);

      repeat (2) @(posedge clk);
      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
